crc32_frame_ctrl: RTL and testbench

Frame-level sequencer for the CRC32 slicing-by-4 core on the 10G MAC datapath. It accepts a framed word stream with byte enables and owns the running CRC state register, seeding it at frame start and feeding it back on every accepted beat. At end of frame it presents the final FCS together with a receive-side residue check. It sits between the MAC TX/RX word pipeline and the `crc32` instance, which it contains and uses as combinational next-state logic.

---
 rtl/crc32_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_crc32_frame_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc32_frame_ctrl (with embedded crc32 core)
// Description : Frame sequencer for the CRC32 datapath. Owns the running CRC
//               state, seeds it at frame start, presents the final FCS and a
//               receive-side residue check, and flags byte-enable violations.
// Revision    : 1.0 - initial release
// ============================================================================

// Combinational reflected CRC32 next-state over the enabled bytes of a word.
// Byte 0 ([7:0]) is folded in first; disabled bytes leave the state untouched.
module crc32 #(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32
) (
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [DATA_WIDTH/8-1:0] i_data_valid,
   input  logic [CRC_WIDTH-1:0]    i_crc_state,
   output logic [CRC_WIDTH-1:0]    o_crc
);
   localparam logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(32'hEDB88320);

   // Unrolled byte-then-bit update; the loops flatten into parallel XOR trees.
   always_comb begin
      logic [CRC_WIDTH-1:0] c;
      c = i_crc_state;
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
         if (i_data_valid[b]) begin
            c = c ^ {{(CRC_WIDTH-8){1'b0}}, i_data[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
               c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            end
         end
      end
      o_crc = c;
   end
endmodule

module crc32_frame_ctrl #(
   parameter int                   DATA_WIDTH  = 32,
   parameter int                   CRC_WIDTH   = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT    = 32'hFFFFFFFF,
   parameter logic [CRC_WIDTH-1:0] CRC_RESIDUE = 32'hDEBB20E3
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_clear,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic [DATA_WIDTH/8-1:0] s_keep,
   input  logic                    s_last,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [CRC_WIDTH-1:0]    m_crc,
   output logic                    m_crc_good,
   output logic                    m_crc_valid,
   input  logic                    m_crc_ready,
   output logic                    o_keep_err,
   output logic                    o_busy
);
   localparam int KEEP_WIDTH = DATA_WIDTH/8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [CRC_WIDTH-1:0] crc_q;
   logic [CRC_WIDTH-1:0] crc_nxt;
   logic                 err_sticky;
   logic                 accept;
   logic                 result_done;
   logic                 keep_noncontig;
   logic                 keep_partial;
   logic                 keep_bad;

   crc32 #(
      .DATA_WIDTH (DATA_WIDTH),
      .CRC_WIDTH  (CRC_WIDTH)
   ) u_crc32 (
      .i_data       (s_data),
      .i_data_valid (s_keep),
      .i_crc_state  (crc_q),
      .o_crc        (crc_nxt)
   );

   // A contiguous-from-LSB mask has no carry overlap with itself plus one.
   assign keep_noncontig = |(s_keep & (s_keep + KEEP_WIDTH'(1)));
   assign keep_partial   = !s_last && !(&s_keep);
   assign keep_bad       = keep_noncontig || keep_partial;
   assign accept         = s_valid && s_ready;
   assign result_done    = m_crc_valid && m_crc_ready;

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Next-state logic; clear overrides every other event.
   always_comb begin
      state_nxt = state;
      if (i_clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_ACCUM: if (accept) state_nxt = s_last ? ST_RESULT : ST_ACCUM;
            ST_RESULT:         if (m_crc_ready) state_nxt = ST_IDLE;
            default:           state_nxt = ST_IDLE;
         endcase
      end
   end

   // Handshake/status outputs decoded from state; s_ready ignores m_crc_ready.
   always_comb begin
      s_ready     = (state != ST_RESULT) && !i_clear;
      m_crc_valid = (state == ST_RESULT);
      o_busy      = (state == ST_ACCUM);
   end

   // CRC state, registered result and error tracking.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         crc_q      <= CRC_INIT;
         m_crc      <= '0;
         m_crc_good <= 1'b0;
         err_sticky <= 1'b0;
         o_keep_err <= 1'b0;
      end else begin
         o_keep_err <= 1'b0;
         if (i_clear) begin
            crc_q      <= CRC_INIT;
            m_crc      <= '0;
            m_crc_good <= 1'b0;
            err_sticky <= 1'b0;
         end else if (accept) begin
            crc_q      <= crc_nxt;
            o_keep_err <= keep_bad;
            err_sticky <= err_sticky || keep_bad;
            if (s_last) begin
               // Result is captured from the post-update state so it is stable in RESULT.
               m_crc      <= ~crc_nxt;
               m_crc_good <= (crc_nxt == CRC_RESIDUE) && !err_sticky && !keep_bad;
            end
         end else if (result_done) begin
            crc_q      <= CRC_INIT;
            m_crc      <= '0;
            m_crc_good <= 1'b0;
            err_sticky <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_crc32_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc32_frame_ctrl
// Description : Directed, table-driven bench for crc32_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc32_frame_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [31:0] data;
   logic [3:0]  keep;
   logic        last;
   logic        valid;
   logic        ready;
   logic [31:0] crc;
   logic        good;
   logic        cvalid;
   logic        cready;
   logic        kerr;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [31:0] CRC_123 = 32'hCBF43926;
   localparam logic [31:0] CRC_RES = 32'h2144DF1C;   // ~DEBB20E3

   crc32_frame_ctrl dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_clear     (clr),
      .s_data      (data),
      .s_keep      (keep),
      .s_last      (last),
      .s_valid     (valid),
      .s_ready     (ready),
      .m_crc       (crc),
      .m_crc_good  (good),
      .m_crc_valid (cvalid),
      .m_crc_ready (cready),
      .o_keep_err  (kerr),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        valid;
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        mrdy;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_crc;
      logic        e_good;
      logic        e_kerr;
      logic        e_busy;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic mr);
      valid  = v;
      data   = d;
      keep   = k;
      last   = l;
      cready = mr;
   endtask

   // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_123(input logic mr_last);
      drive(1, 32'h34333231, 4'hF, 0, 0); step();
      drive(1, 32'h38373635, 4'hF, 0, 0); step();
      drive(1, 32'h00000039, 4'h1, 1, mr_last); step();
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      drive(0, 32'h0, 4'h0, 0, 0);
      #3;
      chk("reset s_ready", ready, 1);
      chk("reset m_crc_valid", cvalid, 0);
      chk("reset m_crc", crc, 0);
      chk("reset m_crc_good", good, 0);
      chk("reset keep_err", kerr, 0);
      chk("reset busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Frame A: "123456789"
      vecs[0]  = '{1'b0,1'b1,32'h34333231,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[1]  = '{1'b0,1'b1,32'h38373635,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[2]  = '{1'b0,1'b1,32'h00000039,4'h1,1'b1,1'b0, 1'b0,1'b1,CRC_123,  1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b0,32'h0,       4'h0,1'b0,1'b1, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b0};
      // Frame B: FCS appended but word 3 is a partial non-last beat
      vecs[4]  = '{1'b0,1'b1,32'h34333231,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[5]  = '{1'b0,1'b1,32'h38373635,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[6]  = '{1'b0,1'b1,32'h00000039,4'h1,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b1,1'b1};
      vecs[7]  = '{1'b0,1'b1,32'hCBF43926,4'hF,1'b1,1'b0, 1'b0,1'b1,CRC_RES,  1'b0,1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b0,32'h0,       4'h0,1'b0,1'b1, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b0};
      // Frame C: same 13 bytes packed legally
      vecs[9]  = '{1'b0,1'b1,32'h34333231,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[10] = '{1'b0,1'b1,32'h38373635,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[11] = '{1'b0,1'b1,32'hF4392639,4'hF,1'b0,1'b0, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1};
      vecs[12] = '{1'b0,1'b1,32'h000000CB,4'h1,1'b1,1'b0, 1'b0,1'b1,CRC_RES,  1'b1,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b0,32'h0,       4'h0,1'b0,1'b1, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b0};
      // Zero-byte frame
      vecs[14] = '{1'b0,1'b1,32'h0,       4'h0,1'b1,1'b0, 1'b0,1'b1,32'h0,    1'b0,1'b0,1'b0};
      vecs[15] = '{1'b0,1'b0,32'h0,       4'h0,1'b0,1'b1, 1'b1,1'b0,32'h0,    1'b0,1'b0,1'b0};

      for (int i = 0; i < 16; i++) begin
         clr = vecs[i].clr;
         drive(vecs[i].valid, vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].mrdy);
         step();
         chk($sformatf("vec%0d s_ready", i),     ready,  vecs[i].e_rdy);
         chk($sformatf("vec%0d m_crc_valid", i), cvalid, vecs[i].e_vld);
         chk($sformatf("vec%0d m_crc", i),       crc,    vecs[i].e_crc);
         chk($sformatf("vec%0d m_crc_good", i),  good,   vecs[i].e_good);
         chk($sformatf("vec%0d keep_err", i),    kerr,   vecs[i].e_kerr);
         chk($sformatf("vec%0d busy", i),        busy,   vecs[i].e_busy);
      end

      // Result stall with s_valid held high: no acceptance, result held.
      send_123(0);
      chk("stall entry valid", cvalid, 1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'hDEADBEEF, 4'hF, 0, 0);
         #1;
         chk($sformatf("stall%0d s_ready", i), ready, 0);
         step();
         chk($sformatf("stall%0d m_crc_valid", i), cvalid, 1);
         chk($sformatf("stall%0d m_crc", i), crc, CRC_123);
      end
      drive(0, 32'h0, 4'h0, 0, 1); step();
      chk("stall release valid", cvalid, 0);
      chk("stall release ready", ready, 1);
      send_123(0);
      chk("reseed crc", crc, CRC_123);
      chk("reseed valid", cvalid, 1);
      drive(0, 32'h0, 4'h0, 0, 1); step();

      // Clear after two beats, with a beat presented during clear.
      drive(1, 32'h34333231, 4'hF, 0, 0); step();
      drive(1, 32'h38373635, 4'hF, 0, 0); step();
      chk("preclear busy", busy, 1);
      clr = 1'b1;
      drive(1, 32'h11111111, 4'hF, 0, 0);
      #1;
      chk("clear s_ready", ready, 0);
      step();
      clr = 1'b0;
      chk("postclear busy", busy, 0);
      chk("postclear valid", cvalid, 0);
      send_123(0);
      chk("after clear crc", crc, CRC_123);
      chk("after clear good", good, 0);

      // Reset while a result is pending.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst mid valid", cvalid, 0);
      chk("rst mid crc", crc, 0);
      chk("rst mid good", good, 0);
      chk("rst mid ready", ready, 1);
      chk("rst mid busy", busy, 0);
      chk("rst mid kerr", kerr, 0);
      drive(0, 32'h0, 4'h0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Non-contiguous keep on a last beat: error pulse, good forced low.
      drive(1, 32'h0, 4'h5, 1, 0); step();
      chk("noncontig kerr", kerr, 1);
      chk("noncontig valid", cvalid, 1);
      chk("noncontig good", good, 0);
      drive(0, 32'h0, 4'h0, 0, 0); step();
      chk("noncontig kerr pulse", kerr, 0);
      drive(0, 32'h0, 4'h0, 0, 1); step();
      chk("noncontig exit", cvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
